// File: rtl/ccff_chain_loader_pkg.sv
// Shared types for the ccff chain loader: controller state encoding and
// counter sizing helper.
package ccff_chain_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_e;

  // Width of a counter that must represent 0..n without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Readback packer: accumulates chain tail bits into words, left-justifies a
// short final word, and presents words through a valid/ready holding register.
module ccff_rb_packer
  import ccff_chain_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              clear,
  input  logic              sample,
  input  logic              tail_bit,
  input  logic              flush,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              stall,
  output logic              drained
);

  localparam int IW = cnt_width(WORD_W);
  localparam logic [IW-1:0] FULL_C = IW'(WORD_W);
  localparam logic [IW-1:0] ZERO_C = {IW{1'b0}};

  logic [WORD_W-1:0] acc_r;
  logic [IW-1:0]     acc_cnt_r;
  logic [WORD_W-1:0] rb_data_r;
  logic              rb_valid_r;
  logic              hold_free_s;
  logic              acc_full_s;
  logic              xfer_s;
  logic [IW-1:0]     shamt_s;

  // Transfer decision: a full word, or any residue while flushing, moves once the holder frees.
  always_comb begin
    hold_free_s = !rb_valid_r || rb_ready;
    acc_full_s  = (acc_cnt_r == FULL_C);
    xfer_s      = hold_free_s && (acc_full_s || (flush && (acc_cnt_r != ZERO_C)));
    shamt_s     = FULL_C - acc_cnt_r;
  end

  // Accumulator and holding register; a new bit may enter in the same cycle the full word leaves.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      acc_r      <= {WORD_W{1'b0}};
      acc_cnt_r  <= ZERO_C;
      rb_data_r  <= {WORD_W{1'b0}};
      rb_valid_r <= 1'b0;
    end else begin
      if (xfer_s) begin
        rb_data_r  <= acc_r << shamt_s;
        rb_valid_r <= 1'b1;
      end else if (rb_valid_r && rb_ready) begin
        rb_valid_r <= 1'b0;
      end else begin
        rb_valid_r <= rb_valid_r;
      end

      if (clear) begin
        acc_r     <= {WORD_W{1'b0}};
        acc_cnt_r <= ZERO_C;
      end else if (sample && xfer_s) begin
        acc_r     <= {{(WORD_W-1){1'b0}}, tail_bit};
        acc_cnt_r <= IW'(1);
      end else if (sample) begin
        acc_r     <= {acc_r[WORD_W-2:0], tail_bit};
        acc_cnt_r <= acc_cnt_r + IW'(1);
      end else if (xfer_s) begin
        acc_r     <= {WORD_W{1'b0}};
        acc_cnt_r <= ZERO_C;
      end else begin
        acc_r     <= acc_r;
        acc_cnt_r <= acc_cnt_r;
      end
    end
  end

  assign stall    = acc_full_s && !hold_free_s;
  assign drained  = (acc_cnt_r == ZERO_C) && !rb_valid_r;
  assign rb_data  = rb_data_r;
  assign rb_valid = rb_valid_r;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a CHAIN_LEN-bit configuration flip-flop chain from a word stream while
// reading the chain's previous contents back out as words.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 128,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam int IW = cnt_width(WORD_W);

  loader_state_e     state_r;
  loader_state_e     state_nxt_s;
  logic [CW-1:0]     bit_cnt_r;
  logic [CW-1:0]     bit_cnt_nxt_s;
  logic [IW-1:0]     word_idx_r;
  logic [IW-1:0]     word_idx_nxt_s;
  logic [WORD_W-1:0] word_sr_r;
  logic              shift_s;
  logic              load_s;
  logic              clear_s;
  logic              stall_s;
  logic              drained_s;

  assign bit_cnt_nxt_s  = bit_cnt_r + CW'(1);
  assign word_idx_nxt_s = word_idx_r + IW'(1);

  // Next-state and per-cycle strobes; chain-length exit wins over word exhaustion.
  always_comb begin
    state_nxt_s = state_r;
    shift_s     = 1'b0;
    load_s      = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          clear_s     = 1'b1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (cfg_valid) begin
          load_s      = 1'b1;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_SHIFT: begin
        if (!stall_s) begin
          shift_s = 1'b1;
          if (bit_cnt_nxt_s == CW'(CHAIN_LEN)) begin
            state_nxt_s = ST_FLUSH;
          end else if (word_idx_nxt_s == IW'(WORD_W)) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_FLUSH: begin
        if (drained_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, bit counter and outgoing word shift register.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= {CW{1'b0}};
      word_idx_r <= {IW{1'b0}};
      word_sr_r  <= {WORD_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;

      if (clear_s) begin
        bit_cnt_r <= {CW{1'b0}};
      end else if (shift_s) begin
        bit_cnt_r <= bit_cnt_nxt_s;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end

      if (load_s) begin
        word_sr_r  <= cfg_data;
        word_idx_r <= {IW{1'b0}};
      end else if (shift_s) begin
        word_sr_r  <= {word_sr_r[WORD_W-2:0], 1'b0};
        word_idx_r <= word_idx_nxt_s;
      end else begin
        word_sr_r  <= word_sr_r;
        word_idx_r <= word_idx_r;
      end
    end
  end

  ccff_rb_packer #(
    .WORD_W(WORD_W)
  ) u_rb_packer (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .clear       (clear_s),
    .sample      (shift_s),
    .tail_bit    (ccff_tail),
    .flush       (state_r == ST_FLUSH),
    .rb_ready    (rb_ready),
    .rb_data     (rb_data),
    .rb_valid    (rb_valid),
    .stall       (stall_s),
    .drained     (drained_s)
  );

  // Gating with reset guarantees no chain shift on the edge that aborts a load.
  assign ccff_shift_en = shift_s && prog_reset_n;
  assign ccff_head     = (state_r == ST_SHIFT) && word_sr_r[WORD_W-1];
  assign cfg_ready     = (state_r == ST_FETCH);
  assign busy          = (state_r != ST_IDLE);
  assign done          = (state_r == ST_DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: three chain lengths (16, 12, 20) against chain
// models, with expected readback/final contents computed from the bit stream.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n     = 3'b000;
  logic [2:0]  start     = 3'b000;
  logic [2:0]  cfg_valid = 3'b000;
  logic [2:0]  rb_ready  = 3'b000;
  logic [7:0]  cfg_data [3];
  wire  [2:0]  cfg_ready, rb_valid, head, en, busy, done, tail;
  wire  [7:0]  rb_data [3];

  logic [2:0]  pre_ld = 3'b000;
  logic [23:0] pre_val = 24'd0;
  logic [23:0] chain [3];

  int checks = 0;
  int errors = 0;

  function automatic int len_of(input int i);
    case (i)
      0:       return 16;
      1:       return 12;
      default: return 20;
    endcase
  endfunction

  // Behavioural chains: head enters bit 0, tail is the top bit of each length.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pre_ld[i]) chain[i] <= pre_val;
      else if (en[i]) chain[i] <= ((chain[i] << 1) | 24'(head[i])) & ((24'd1 << len_of(i)) - 24'd1);
    end
  end
  assign tail[0] = chain[0][15];
  assign tail[1] = chain[1][11];
  assign tail[2] = chain[2][19];

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut16 (
    .prog_clk(clk), .prog_reset_n(rst_n[0]), .start(start[0]),
    .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]), .cfg_ready(cfg_ready[0]),
    .rb_data(rb_data[0]), .rb_valid(rb_valid[0]), .rb_ready(rb_ready[0]),
    .ccff_head(head[0]), .ccff_tail(tail[0]), .ccff_shift_en(en[0]),
    .busy(busy[0]), .done(done[0]));

  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut12 (
    .prog_clk(clk), .prog_reset_n(rst_n[1]), .start(start[1]),
    .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]), .cfg_ready(cfg_ready[1]),
    .rb_data(rb_data[1]), .rb_valid(rb_valid[1]), .rb_ready(rb_ready[1]),
    .ccff_head(head[1]), .ccff_tail(tail[1]), .ccff_shift_en(en[1]),
    .busy(busy[1]), .done(done[1]));

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut20 (
    .prog_clk(clk), .prog_reset_n(rst_n[2]), .start(start[2]),
    .cfg_data(cfg_data[2]), .cfg_valid(cfg_valid[2]), .cfg_ready(cfg_ready[2]),
    .rb_data(rb_data[2]), .rb_valid(rb_valid[2]), .rb_ready(rb_ready[2]),
    .ccff_head(head[2]), .ccff_tail(tail[2]), .ccff_shift_en(en[2]),
    .busy(busy[2]), .done(done[2]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full load on instance i. words holds the stream MSB-first in [23:0];
  // mode 0: rb_ready=1, 1: rb_ready=0 until cycle rdy_cyc, 2: random.
  task automatic run_load(input string tag, input int i, input logic [23:0] preload,
                          input logic [23:0] words, input int gap, input int mode,
                          input int rdy_cyc, input bit start_mid, input int rst_at);
    int L, nw, wi, gap_left, en_cnt, done_cnt, gap_en, head_err, fetch_head_err, stable_err;
    bit finished, aborted, in_gap, hold_pend;
    logic [7:0]  hold_val;
    logic [31:0] padded;
    logic [23:0] exp_chain;
    logic [7:0]  rbq [$];
    L = len_of(i);
    nw = (L + 7) / 8;
    padded = 32'(preload) << (nw * 8 - L);
    exp_chain = words >> (24 - L);
    wi = 0; gap_left = gap; en_cnt = 0; done_cnt = 0; gap_en = 0;
    head_err = 0; fetch_head_err = 0; stable_err = 0;
    finished = 1'b0; aborted = 1'b0; hold_pend = 1'b0; hold_val = 8'd0;

    @(negedge clk);
    pre_val = preload;
    pre_ld[i] = 1'b1;
    start[i] = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      pre_ld = 3'b000;
      start[i] = 1'b0;
      if (start_mid && en_cnt == 3) start[i] = 1'b1;
      case (mode)
        0:       rb_ready[i] = 1'b1;
        1:       rb_ready[i] = (c >= rdy_cyc);
        default: rb_ready[i] = 1'($urandom_range(0, 1));
      endcase
      if (rst_at >= 0 && en_cnt == rst_at) begin
        rst_n[i] = 1'b0;
        cfg_valid[i] = 1'b0;
        #2;
        check_eq({tag, "_rst_gate"}, 32'(en[i]), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_rst_outs"},
                 {26'd0, cfg_ready[i], rb_valid[i], en[i], head[i], busy[i], done[i]}, 32'd0);
        check_eq({tag, "_rst_rbdata"}, 32'(rb_data[i]), 32'd0);
        @(negedge clk);
        rst_n[i] = 1'b1;
        repeat (10) begin
          @(negedge clk); #1;
          if (en[i]) en_cnt++;
        end
        check_eq({tag, "_rst_en_cnt"}, 32'(en_cnt), 32'(rst_at));
        aborted = 1'b1;
        break;
      end
      #1;
      in_gap = cfg_ready[i] && (wi == 1) && (gap_left > 0);
      if (wi < nw && !in_gap) begin
        cfg_valid[i] = 1'b1;
        cfg_data[i] = 8'(words >> (16 - 8 * wi));
      end else begin
        cfg_valid[i] = 1'b0;
      end
      #1;
      if (in_gap) begin
        gap_left--;
        if (en[i]) gap_en++;
      end
      if (mode == 1 && c == rdy_cyc - 1) begin
        check_eq({tag, "_bp_en"}, 32'(en_cnt), 32'((L < 16) ? L : 16));
        check_eq({tag, "_bp_valid"}, 32'(rb_valid[i]), 32'd1);
        check_eq({tag, "_bp_data"}, 32'(rb_data[i]), 32'(8'(padded >> ((nw - 1) * 8))));
      end
      if (hold_pend && (!rb_valid[i] || rb_data[i] !== hold_val)) stable_err++;
      hold_pend = rb_valid[i] && !rb_ready[i];
      hold_val = rb_data[i];
      if (cfg_ready[i] && head[i]) fetch_head_err++;
      if (en[i]) begin
        if (head[i] !== words[23 - en_cnt]) head_err++;
        en_cnt++;
      end
      if (cfg_valid[i] && cfg_ready[i]) wi++;
      if (rb_valid[i] && rb_ready[i]) rbq.push_back(rb_data[i]);
      if (done[i]) begin
        done_cnt++;
        finished = 1'b1;
        break;
      end
    end
    cfg_valid[i] = 1'b0;
    start[i] = 1'b0;
    if (!aborted) begin
      check_eq({tag, "_finished"}, 32'(finished), 32'd1);
      @(negedge clk); #1;
      check_eq({tag, "_done_pulse"}, {30'd0, done[i], busy[i]}, 32'd0);
      check_eq({tag, "_en_cnt"}, 32'(en_cnt), 32'(L));
      check_eq({tag, "_head_bits"}, 32'(head_err), 32'd0);
      check_eq({tag, "_head_idle"}, 32'(fetch_head_err), 32'd0);
      check_eq({tag, "_rb_stable"}, 32'(stable_err), 32'd0);
      check_eq({tag, "_chain"}, 32'(chain[i]), 32'(exp_chain));
      check_eq({tag, "_words_used"}, 32'(wi), 32'(nw));
      check_eq({tag, "_rb_count"}, 32'(rbq.size()), 32'(nw));
      for (int k = 0; k < nw && k < rbq.size(); k++)
        check_eq({tag, "_rb_word"}, 32'(rbq[k]), 32'(8'(padded >> ((nw - 1 - k) * 8))));
      if (gap > 0) check_eq({tag, "_gap_en"}, 32'(gap_en), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cfg_data[i] = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_outs",
               {26'd0, cfg_ready[i], rb_valid[i], en[i], head[i], busy[i], done[i]}, 32'd0);
      check_eq("reset_rbdata", 32'(rb_data[i]), 32'd0);
    end
    rst_n = 3'b111;

    run_load("basic",      0, 24'h00A5C3, 24'h123400, 0, 0, 0,  1'b0, -1);
    run_load("backpress",  0, 24'h00A5C3, 24'h123400, 0, 1, 30, 1'b0, -1);
    run_load("stall20",    2, 24'h0F3C5A, 24'h9E37B1, 0, 1, 40, 1'b0, -1);
    run_load("nonmult",    1, 24'h000FFF, 24'hABCD00, 0, 0, 0,  1'b0, -1);
    run_load("gap",        0, 24'h00A5C3, 24'h123400, 5, 0, 0,  1'b0, -1);
    run_load("start_mid",  0, 24'h005A3C, 24'h6BE100, 0, 0, 0,  1'b1, -1);
    run_load("reset_mid",  0, 24'h00FFFF, 24'h55AA00, 0, 0, 0,  1'b0, 5);
    run_load("after_rst",  0, 24'h001357, 24'hC0DE00, 0, 0, 0,  1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        run_load("rand", i, 24'($urandom) & ((24'd1 << len_of(i)) - 24'd1), 24'($urandom),
                 $urandom_range(0, 4), 2, 0, 1'($urandom_range(0, 1)), -1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 128: number of configuration flip-flops in the target ccff chain, ccff_head to ccff_tail.
REQ-002 SHALL have parameter WORD_W, default 8: bitstream word width, for both load and readback.
REQ-003 SHALL have port prog_clk, input, 1: the single clock; the chain flops also use this clock.
REQ-004 SHALL have port prog_reset_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a full chain load.
REQ-006 SHALL have port cfg_data, input, WORD_W: bitstream word, MSB shifted first.
REQ-007 SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): load handshake.
REQ-008 SHALL have port rb_data, output, WORD_W: captured previous chain contents, first-out bit in MSB.
REQ-009 SHALL have ports rb_valid (output, 1) and rb_ready (input, 1): readback handshake.
REQ-010 SHALL have port ccff_head, output, 1: serial data into the chain head.
REQ-011 SHALL have port ccff_tail, input, 1: serial data from the chain tail.
REQ-012 SHALL have port ccff_shift_en, output, 1: chain clock enable; the chain shifts on each prog_clk edge while it is high.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1): busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, FETCH, SHIFT, FLUSH and DONE.
REQ-015 IDLE SHALL behave as follows.
- start=1 moves to FETCH and clears the bit counter and the readback accumulator.
- start SHALL be ignored in every other state.
REQ-016 FETCH SHALL behave as follows.
- cfg_ready=1 and ccff_shift_en=0.
- A cfg_valid&cfg_ready transfer loads the word shift register, clears the word bit index and moves to SHIFT.
- cfg_valid low SHALL hold FETCH indefinitely.
REQ-017 SHIFT SHALL behave as follows.
- ccff_head = word shift register MSB.
- ccff_shift_en=1 unless stalled (REQ-019).
- Each enabled cycle: samples ccff_tail into the accumulator LSB, shifts the word register left, increments the bit counter and the word bit index.
REQ-018 SHIFT exits SHALL be taken on the enabled cycle that shifts, as follows.
- Word bit index reaches WORD_W with the counter below CHAIN_LEN: move to FETCH. This costs one bubble cycle per word; no bit is lost or duplicated.
- Bit counter reaches CHAIN_LEN: move to FLUSH. Unused LSBs of the final cfg word are discarded.
REQ-019 Readback packing and stall SHALL work as follows.
- When the accumulator holds WORD_W bits, it transfers to the rb_data holding register, which raises rb_valid.
- If the holding register is still full (rb_valid&!rb_ready), ccff_shift_en SHALL be 0 until the transfer can occur.
REQ-020 rb_valid SHALL stay high, with rb_data stable, until rb_valid&rb_ready.
REQ-021 FLUSH SHALL behave as follows.
- If the accumulator holds k bits, 0<k<WORD_W, push them left-justified with zero LSBs once the holding register is free.
- Then move to DONE. k=0 moves directly once the holding register is empty.
REQ-022 DONE SHALL assert done=1 for exactly one cycle and then move to IDLE.
REQ-023 ccff_head SHALL be 0 and ccff_shift_en SHALL be 0 in every state other than SHIFT.
REQ-024 The total number of ccff_shift_en-high cycles per load SHALL equal CHAIN_LEN exactly.
REQ-025 The bit counter width SHALL be clog2(CHAIN_LEN+1) with no wrap; the word bit index width SHALL be clog2(WORD_W+1).

Reset
REQ-026 On prog_reset_n=0 at a prog_clk edge, the block SHALL:
- enter IDLE;
- drive cfg_ready, rb_valid, ccff_shift_en, ccff_head, busy and done to 0;
- clear rb_data, the counters and the accumulator to 0.
REQ-027 Reset mid-load SHALL abort immediately with no further shifts; chain contents are then undefined until a new full load.

Structure
REQ-028 The state enum and the state encoding SHALL reside in ccff_chain_loader_pkg.
REQ-029 Readback accumulation, left-justify and the holding register SHALL form the sub-module ccff_rb_packer; everything else is inline.

Verification
REQ-030 The bench SHALL use a behavioural chain model of CHAIN_LEN flops clocked by prog_clk and enabled by ccff_shift_en.
REQ-031 Basic load: CHAIN_LEN=16, WORD_W=8, chain preloaded 0xA5C3, rb_ready=1, words 0x12,0x34 -> rb words 0xA5,0xC3; chain = 0x1234; 16 enable cycles; one done pulse.
REQ-032 Backpressure: same stimulus with rb_ready=0 until cycle 30 -> enable drops after 16 shifted bits while rb holds 0xA5; no extra shift; resumes on accept.
REQ-033 Non-multiple length: CHAIN_LEN=12, chain 0xFFF, words 0xAB,0xCD -> chain = 0xABC; rb words 0xFF,0xF0; exactly 12 enable cycles.
REQ-034 Source gap: cfg_valid low 5 cycles between words -> enable low throughout the gap; final chain contents unchanged vs. the no-gap run.
REQ-035 Reset and ignored start:
- start pulsed mid-SHIFT -> ignored, load count unaffected.
- prog_reset_n low after bit 5 -> all outputs 0 next cycle; no further enable cycles.
